sharp_frame_buffer: RTL and testbench

//  Frame store and dirty-line scheduler upstream of Sharp_Driver for the 144x168 LS013B7DH01 memory LCD.

---
 rtl/sharp_lcd_pkg.sv | 29 ++
 rtl/sharp_fb_ram.sv | 31 +++
 rtl/sharp_frame_buffer.sv | 183 ++++++++++++++++++
 tb/tb_sharp_frame_buffer.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sharp_lcd_pkg.sv
// Shared constants and FSM encoding for the Sharp memory LCD path.
// Used by the frame buffer and the downstream serializer.
package sharp_lcd_pkg;

    localparam int LCD_LINES          = 168;
    localparam int LCD_BYTES_PER_LINE = 18;
    localparam int LINE_W             = 8;
    localparam int COL_W              = 5;
    localparam int ADDR_W             = 12;
    localparam int FB_DEPTH           = LCD_LINES * LCD_BYTES_PER_LINE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_FETCH,
        ST_STREAM,
        ST_DONE
    } fb_state_t;

    function automatic logic [ADDR_W-1:0] fb_addr(
        input logic [LINE_W-1:0] line,
        input logic [COL_W-1:0]  col
    );
        logic [ADDR_W-1:0] bpl;
        bpl = ADDR_W'(LCD_BYTES_PER_LINE);
        fb_addr = ADDR_W'(line) * bpl + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/sharp_fb_ram.sv
// Simple dual-port byte RAM holding the whole frame.
// One write port, one registered read port; contents are never reset.
module sharp_fb_ram
    import sharp_lcd_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [0:FB_DEPTH-1];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; holds its value while re is low
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sharp_frame_buffer.sv
// Frame store with dirty-line tracking for the 144x168 Sharp memory LCD.
// Streams only modified lines, one byte per beat, to the serializer.
module sharp_frame_buffer
    import sharp_lcd_pkg::*;
(
    input  logic              clk_12mhz,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [LINE_W-1:0] wr_line,
    input  logic [COL_W-1:0]  wr_col,
    input  logic [7:0]        wr_data,
    input  logic              refresh_req,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic [LINE_W-1:0] out_line,
    output logic              out_first,
    output logic              out_last,
    output logic              frame_done
);

    localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LCD_LINES - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(LCD_BYTES_PER_LINE - 1);

    fb_state_t          state, state_nxt;
    logic [LINE_W-1:0]  ptr, ptr_nxt;
    logic [COL_W-1:0]   col, col_nxt;
    logic [LCD_LINES-1:0] dirty;
    logic               pending;
    logic               busy_q;
    logic               done_q;
    logic [LINE_W-1:0]  line_q;
    logic               first_q;
    logic               last_q;
    logic               wr_ok;
    logic               clr_dirty;
    logic               rd_en;
    logic               start;
    logic [7:0]         rd_data;

    assign wr_ok = wr_en
                && (wr_line < LINE_W'(LCD_LINES))
                && (wr_col < COL_W'(LCD_BYTES_PER_LINE));

    sharp_fb_ram u_ram (
        .clk   (clk_12mhz),
        .we    (wr_ok),
        .waddr (fb_addr(wr_line, wr_col)),
        .wdata (wr_data),
        .re    (rd_en),
        .raddr (fb_addr(ptr, col)),
        .rdata (rd_data)
    );

    // Next-state and per-cycle control for the scan/stream scheduler
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        col_nxt   = col;
        clr_dirty = 1'b0;
        rd_en     = 1'b0;
        start     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (refresh_req || pending) begin
                    state_nxt = ST_SCAN;
                    ptr_nxt   = '0;
                    start     = 1'b1;
                end
            end
            ST_SCAN: begin
                if (dirty[ptr]) begin
                    state_nxt = ST_FETCH;
                    col_nxt   = '0;
                    clr_dirty = 1'b1;
                end else if (ptr == LAST_LINE) begin
                    state_nxt = ST_DONE;
                end else begin
                    ptr_nxt = ptr + LINE_W'(1);
                end
            end
            ST_FETCH: begin
                rd_en     = 1'b1;
                state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (out_ready) begin
                    if (col != LAST_COL) begin
                        state_nxt = ST_FETCH;
                        col_nxt   = col + COL_W'(1);
                    end else if (ptr == LAST_LINE) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_SCAN;
                        ptr_nxt   = ptr + LINE_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, scan pointer and byte column registers
    always_ff @(posedge clk_12mhz) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr   <= '0;
            col   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            col   <= col_nxt;
        end
    end

    // Dirty bits: a host write overrides a same-cycle scan clear
    always_ff @(posedge clk_12mhz) begin
        if (!rst_n) begin
            dirty <= '1;
        end else begin
            if (clr_dirty) begin
                dirty[ptr] <= 1'b0;
            end
            if (wr_ok) begin
                dirty[wr_line] <= 1'b1;
            end
        end
    end

    // Requests arriving mid-pass collapse into one pending pass
    always_ff @(posedge clk_12mhz) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (start) begin
            pending <= 1'b0;
        end else if (refresh_req) begin
            pending <= 1'b1;
        end
    end

    // Pass status: busy spans the pass, frame_done pulses as it drops
    always_ff @(posedge clk_12mhz) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == ST_DONE);
            if (start) begin
                busy_q <= 1'b1;
            end else if (state == ST_DONE) begin
                busy_q <= 1'b0;
            end
        end
    end

    // Beat sideband captured alongside the RAM read
    always_ff @(posedge clk_12mhz) begin
        if (!rst_n) begin
            line_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (rd_en) begin
            line_q  <= ptr + LINE_W'(1);
            first_q <= (col == '0);
            last_q  <= (col == LAST_COL);
        end
    end

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign out_valid  = (state == ST_STREAM);
    assign out_data   = out_valid ? rd_data : 8'h00;
    assign out_line   = line_q;
    assign out_first  = out_valid & first_q;
    assign out_last   = out_valid & last_q;

endmodule

// File: tb/tb_sharp_frame_buffer.sv
// Scoreboard bench for sharp_frame_buffer.
// Expected beats come from a byte/dirty model of the panel.
module tb_sharp_frame_buffer;
    import sharp_lcd_pkg::*;

    logic              clk_12mhz = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [LINE_W-1:0] wr_line;
    logic [COL_W-1:0]  wr_col;
    logic [7:0]        wr_data;
    logic              refresh_req;
    logic              busy;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic [LINE_W-1:0] out_line;
    logic              out_first;
    logic              out_last;
    logic              frame_done;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] line;
        logic       first;
        logic       last;
    } beat_t;

    beat_t      sbq[$];
    logic [7:0] mem_m [0:FB_DEPTH-1];
    bit         mdirty [0:LCD_LINES-1];
    int         checks = 0;
    int         errors = 0;

    sharp_frame_buffer dut (
        .clk_12mhz   (clk_12mhz),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_line     (wr_line),
        .wr_col      (wr_col),
        .wr_data     (wr_data),
        .refresh_req (refresh_req),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_line    (out_line),
        .out_first   (out_first),
        .out_last    (out_last),
        .frame_done  (frame_done)
    );

    always #5 clk_12mhz = ~clk_12mhz;

    function automatic logic [7:0] pat(input int l, input int c);
        return 8'((l * 31 + c * 7 + 3) ^ (l >> 2));
    endfunction

    task automatic write_byte(input int l, input int c, input logic [7:0] d);
        @(negedge clk_12mhz);
        wr_en   = 1'b1;
        wr_line = 8'(l);
        wr_col  = 5'(c);
        wr_data = d;
        if (l < LCD_LINES && c < LCD_BYTES_PER_LINE) begin
            mem_m[l*LCD_BYTES_PER_LINE+c] = d;
            mdirty[l] = 1'b1;
        end
        @(negedge clk_12mhz);
        wr_en = 1'b0;
    endtask

    task automatic push_pass();
        for (int l = 0; l < LCD_LINES; l++) begin
            if (mdirty[l]) begin
                for (int c = 0; c < LCD_BYTES_PER_LINE; c++) begin
                    sbq.push_back(beat_t'{
                        data:  mem_m[l*LCD_BYTES_PER_LINE+c],
                        line:  8'(l + 1),
                        first: (c == 0),
                        last:  (c == LCD_BYTES_PER_LINE - 1)});
                end
                mdirty[l] = 1'b0;
            end
        end
    endtask

    // rmode 0: ready always; 1: ready one cycle in three.
    // inj >= 0: write line inj and pulse refresh at its first beat.
    task automatic collect(input int rmode, input bit pulse, input int inj,
                           output int beats, output int first_at,
                           output int done_at);
        bit    injected;
        bit    prev_stall;
        beat_t prev;
        beat_t cur;
        beat_t exp_b;
        injected   = 1'b0;
        prev_stall = 1'b0;
        prev       = '0;
        beats      = 0;
        first_at   = -1;
        done_at    = -1;
        if (pulse) begin
            @(negedge clk_12mhz);
            refresh_req = 1'b1;
        end
        for (int i = 1; i <= 20000; i++) begin
            @(negedge clk_12mhz);
            refresh_req = 1'b0;
            wr_en       = 1'b0;
            out_ready   = (rmode == 0) ? 1'b1 : (i % 3 == 0);
            cur = {out_data, out_line, out_first, out_last};
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || cur !== prev) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0b %h want v=1 %h",
                             out_valid, cur, prev);
                end
            end
            if (out_valid && first_at < 0) first_at = i;
            if (inj >= 0 && !injected && out_valid && out_first
                && out_line == 8'(inj + 1)) begin
                injected    = 1'b1;
                wr_en       = 1'b1;
                wr_line     = 8'(inj);
                wr_col      = '0;
                wr_data     = 8'hC3;
                refresh_req = 1'b1;
                mem_m[inj*LCD_BYTES_PER_LINE] = 8'hC3;
                mdirty[inj] = 1'b1;
            end
            if (out_valid && out_ready) begin
                beats++;
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL extra_beat: got %h want none", cur);
                end else begin
                    exp_b = sbq.pop_front();
                    if (cur !== exp_b) begin
                        errors++;
                        $display("FAIL beat: got %h want %h", cur, exp_b);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev       = cur;
            if (frame_done === 1'b1) begin
                done_at = i;
                checks++;
                if (busy !== 1'b0 || out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL done_state: got busy=%0b v=%0b want 0 0",
                             busy, out_valid);
                end
                checks++;
                if (sbq.size() != 0) begin
                    errors++;
                    $display("FAIL missing_beats: got %0d left want 0",
                             sbq.size());
                end
                break;
            end
        end
        if (done_at < 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no frame_done want one");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk_12mhz);
        checks++;
        if ({busy, out_valid, out_first, out_last, frame_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {busy, out_valid, out_first, out_last, frame_done});
        end
        checks++;
        if (out_data !== 8'h00 || out_line !== 8'h00) begin
            errors++;
            $display("FAIL reset_data: got %h/%h want 00/00",
                     out_data, out_line);
        end
        rst_n = 1'b1;
        for (int l = 0; l < LCD_LINES; l++) mdirty[l] = 1'b1;
    endtask

    task automatic fill_frame();
        for (int l = 0; l < LCD_LINES; l++) begin
            for (int c = 0; c < LCD_BYTES_PER_LINE; c++) begin
                @(negedge clk_12mhz);
                wr_en   = 1'b1;
                wr_line = 8'(l);
                wr_col  = 5'(c);
                wr_data = pat(l, c);
                mem_m[l*LCD_BYTES_PER_LINE+c] = pat(l, c);
                mdirty[l] = 1'b1;
            end
        end
        @(negedge clk_12mhz);
        wr_en = 1'b0;
    endtask

    task automatic test_full_frame();
        int b, f, d;
        push_pass();
        collect(0, 1'b1, -1, b, f, d);
        checks++;
        if (b != FB_DEPTH) begin
            errors++;
            $display("FAIL full_beats: got %0d want %0d", b, FB_DEPTH);
        end
        checks++;
        if (f != 3) begin
            errors++;
            $display("FAIL full_latency: got %0d want 3", f);
        end
        @(negedge clk_12mhz);
        checks++;
        if (frame_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got fd=%0b busy=%0b want 0 0",
                     frame_done, busy);
        end
    endtask

    task automatic test_single_write();
        int b, f, d;
        write_byte(5, 3, 8'hA5);
        push_pass();
        collect(0, 1'b1, -1, b, f, d);
        checks++;
        if (b != LCD_BYTES_PER_LINE) begin
            errors++;
            $display("FAIL single_beats: got %0d want 18", b);
        end
        checks++;
        if (f != 8) begin
            errors++;
            $display("FAIL single_latency: got %0d want 8", f);
        end
    endtask

    task automatic test_stall();
        int b, f, d;
        write_byte(5, 0, 8'h3C);
        write_byte(5, 17, 8'hE1);
        push_pass();
        collect(1, 1'b1, -1, b, f, d);
        checks++;
        if (b != LCD_BYTES_PER_LINE) begin
            errors++;
            $display("FAIL stall_beats: got %0d want 18", b);
        end
    endtask

    task automatic test_pending();
        int b, f, d;
        write_byte(9, 4, 8'h99);
        push_pass();
        collect(0, 1'b1, 9, b, f, d);
        checks++;
        if (b != LCD_BYTES_PER_LINE) begin
            errors++;
            $display("FAIL pend_first_beats: got %0d want 18", b);
        end
        push_pass();
        @(negedge clk_12mhz);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL pend_restart: got busy=%0b want 1", busy);
        end
        collect(0, 1'b0, -1, b, f, d);
        checks++;
        if (b != LCD_BYTES_PER_LINE) begin
            errors++;
            $display("FAIL pend_second_beats: got %0d want 18", b);
        end
    endtask

    task automatic test_empty_and_oob();
        int b, f, d;
        collect(0, 1'b1, -1, b, f, d);
        checks++;
        if (b != 0 || d != LCD_LINES + 2) begin
            errors++;
            $display("FAIL empty_pass: got beats=%0d done=%0d want 0 %0d",
                     b, d, LCD_LINES + 2);
        end
        write_byte(168, 0, 8'hFF);
        write_byte(0, 18, 8'hFF);
        write_byte(200, 2, 8'hFF);
        collect(0, 1'b1, -1, b, f, d);
        checks++;
        if (b != 0) begin
            errors++;
            $display("FAIL oob_dirty: got %0d beats want 0", b);
        end
        write_byte(1, 5, 8'h55);
        push_pass();
        collect(0, 1'b1, -1, b, f, d);
        checks++;
        if (b != LCD_BYTES_PER_LINE) begin
            errors++;
            $display("FAIL oob_ram_beats: got %0d want 18", b);
        end
    endtask

    task automatic test_reset_mid();
        int  b, f, d;
        bit  hit;
        hit = 1'b0;
        write_byte(7, 0, 8'h77);
        @(negedge clk_12mhz);
        refresh_req = 1'b1;
        out_ready   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_12mhz);
            refresh_req = 1'b0;
            if (out_valid && out_line == 8'd8 && !out_first) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL mid_reach: got no mid-line beat want one");
        end
        rst_n = 1'b0;
        @(negedge clk_12mhz);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0
            || out_line !== 8'h00 || out_data !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: got v=%0b busy=%0b line=%h want 0 0 00",
                     out_valid, busy, out_line);
        end
        rst_n = 1'b1;
        sbq.delete();
        for (int l = 0; l < LCD_LINES; l++) mdirty[l] = 1'b1;
        push_pass();
        collect(0, 1'b1, -1, b, f, d);
        checks++;
        if (b != FB_DEPTH) begin
            errors++;
            $display("FAIL post_reset_beats: got %0d want %0d", b, FB_DEPTH);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        wr_en       = 1'b0;
        wr_line     = '0;
        wr_col      = '0;
        wr_data     = '0;
        refresh_req = 1'b0;
        out_ready   = 1'b1;
        test_reset();
        fill_frame();
        test_full_frame();
        test_single_write();
        test_stall();
        test_pending();
        test_empty_and_oob();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
